// File: rtl/johnson_decoder_pkg.sv
// rtl/johnson_decoder_pkg.sv - shared types and index-width helper for the Johnson decoder
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } fsm_state_e;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2,
      STEP_JUMP = 2'd3
   } step_e;

   function automatic int idx_width(input int width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - codeword input and decoded-result bundle
// err_cnt exists only when JOHNSON_DECODER_ERRCNT_EN is defined.
interface johnson_decoder_if #(
   parameter int WIDTH = 8
);
   import johnson_pkg::*;
   localparam int IW = idx_width(WIDTH);

   logic [WIDTH-1:0] code_in;
   logic             code_valid;
   logic [IW-1:0]    idx_out;
   logic             idx_valid;
   logic             dir;
   logic             illegal;
   logic             jump;
   logic             locked;
`ifdef JOHNSON_DECODER_ERRCNT_EN
   logic [7:0]       err_cnt;
`endif

   modport master (
`ifdef JOHNSON_DECODER_ERRCNT_EN
      input  err_cnt,
`endif
      output code_in, code_valid,
      input  idx_out, idx_valid, dir, illegal, jump, locked
   );

   modport slave (
`ifdef JOHNSON_DECODER_ERRCNT_EN
      output err_cnt,
`endif
      input  code_in, code_valid,
      output idx_out, idx_valid, dir, illegal, jump, locked
   );
endinterface

// File: rtl/johnson_decoder_code_check.sv
// rtl/johnson_decoder_code_check.sv - combinational Johnson legality check and index decode
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int IW = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] code,
   output logic             legal,
   output logic [IW-1:0]    idx
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] inv;
   logic [IW-1:0]    pc;

   always_comb begin
      inv = ~code;
      pc  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pc = pc + IW'(code[i]);
      end
      // x & (x+1) == 0 holds only for a run of ones anchored at bit 0 (or zero)
      legal = ((code & (code + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
      if (code[WIDTH-1]) begin
         idx = pc;
      end else if (code == '0) begin
         idx = '0;
      end else begin
         idx = IW'(2 * WIDTH) - pc;
      end
   end
endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - two-stage Johnson codeword decoder with step classification and lock FSM
// Optional error counter output enabled by JOHNSON_DECODER_ERRCNT_EN.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int LOCK_COUNT  = 4,
   parameter int UNLOCK_ERRS = 2
) (
   input  logic clk,
   input  logic rst,
   johnson_decoder_if.slave bus
);
   localparam int IW = idx_width(WIDTH);
   localparam logic [IW:0] NSTATES = (IW+1)'(2 * WIDTH);
   localparam logic [1:0] S_SEARCH = ST_SEARCH;
   localparam logic [1:0] S_TRACK  = ST_TRACK;
   localparam logic [1:0] S_LOCKED = ST_LOCKED;

   logic          chk_legal;
   logic [IW-1:0] chk_idx;

   johnson_code_check #(.WIDTH(WIDTH)) u_check (
      .code  (bus.code_in),
      .legal (chk_legal),
      .idx   (chk_idx)
   );

   logic          s1_valid_q, s1_valid_d;
   logic          s1_legal_q, s1_legal_d;
   logic [IW-1:0] s1_idx_q,   s1_idx_d;
   logic [IW-1:0] prev_idx_q, prev_idx_d;
   logic [IW-1:0] idx_out_q,  idx_out_d;
   logic          idx_valid_q, idx_valid_d;
   logic          illegal_q,  illegal_d;
   logic          jump_q,     jump_d;
   logic          dir_q,      dir_d;
   logic [1:0]    state_q,    state_d;
   logic [3:0]    good_cnt_q, good_cnt_d;
   logic [3:0]    bad_cnt_q,  bad_cnt_d;
   logic [IW:0]   delta;
   step_e         step_cls;

   always_comb begin
      s1_valid_d = bus.code_valid;
      s1_legal_d = chk_legal;
      s1_idx_d   = chk_idx;

      // modular distance without assuming 2*WIDTH is a power of two
      if (s1_idx_q >= prev_idx_q) begin
         delta = {1'b0, s1_idx_q} - {1'b0, prev_idx_q};
      end else begin
         delta = {1'b0, s1_idx_q} + NSTATES - {1'b0, prev_idx_q};
      end
      if (delta == '0)                       step_cls = STEP_HOLD;
      else if (delta == (IW+1)'(1))          step_cls = STEP_UP;
      else if (delta == NSTATES - (IW+1)'(1)) step_cls = STEP_DOWN;
      else                                   step_cls = STEP_JUMP;

      idx_valid_d = 1'b0;
      illegal_d   = 1'b0;
      jump_d      = 1'b0;
      idx_out_d   = idx_out_q;
      prev_idx_d  = prev_idx_q;
      dir_d       = dir_q;
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;

      if (s1_valid_q && !s1_legal_q) begin
         illegal_d = 1'b1;
         if (state_q == S_TRACK) begin
            state_d = S_SEARCH;
         end else if (state_q == S_LOCKED) begin
            bad_cnt_d = bad_cnt_q + 4'd1;
            if (bad_cnt_d == 4'(UNLOCK_ERRS)) state_d = S_SEARCH;
         end
      end else if (s1_valid_q) begin
         idx_valid_d = 1'b1;
         idx_out_d   = s1_idx_q;
         prev_idx_d  = s1_idx_q;
         jump_d      = (step_cls == STEP_JUMP);
         if (step_cls == STEP_UP)   dir_d = 1'b1;
         if (step_cls == STEP_DOWN) dir_d = 1'b0;
         case (state_q)
            S_SEARCH: begin
               state_d    = S_TRACK;
               good_cnt_d = 4'd0;
            end
            S_TRACK: begin
               if (step_cls == STEP_UP || step_cls == STEP_DOWN) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if (good_cnt_d == 4'(LOCK_COUNT)) begin
                     state_d   = S_LOCKED;
                     bad_cnt_d = 4'd0;
                  end
               end else if (step_cls == STEP_JUMP) begin
                  good_cnt_d = 4'd0;
               end
            end
            S_LOCKED: begin
               if (step_cls == STEP_JUMP) begin
                  bad_cnt_d = bad_cnt_q + 4'd1;
                  if (bad_cnt_d == 4'(UNLOCK_ERRS)) state_d = S_SEARCH;
               end else begin
                  bad_cnt_d = 4'd0;
               end
            end
            default: state_d = S_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_legal_q  <= 1'b0;
         s1_idx_q    <= '0;
         prev_idx_q  <= '0;
         idx_out_q   <= '0;
         idx_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         jump_q      <= 1'b0;
         dir_q       <= 1'b0;
         state_q     <= S_SEARCH;
         good_cnt_q  <= 4'd0;
         bad_cnt_q   <= 4'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_legal_q  <= s1_legal_d;
         s1_idx_q    <= s1_idx_d;
         prev_idx_q  <= prev_idx_d;
         idx_out_q   <= idx_out_d;
         idx_valid_q <= idx_valid_d;
         illegal_q   <= illegal_d;
         jump_q      <= jump_d;
         dir_q       <= dir_d;
         state_q     <= state_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
      end
   end

   assign bus.idx_out   = idx_out_q;
   assign bus.idx_valid = idx_valid_q;
   assign bus.illegal   = illegal_q;
   assign bus.jump      = jump_q;
   assign bus.dir       = dir_q;
   assign bus.locked    = (state_q == S_LOCKED);

`ifdef JOHNSON_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((illegal_d || jump_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= 8'd0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - scoreboard bench for johnson_decoder (WIDTH=8, LOCK_COUNT=4, UNLOCK_ERRS=2)
module tb_johnson_decoder;
   localparam int W      = 8;
   localparam int NS     = 2 * W;
   localparam int LOCK   = 4;
   localparam int UNLOCK = 2;

   typedef struct {
      int         due;
      bit         valid;
      bit         illegal;
      bit         jump;
      logic [3:0] idx;
      bit         dir;
      bit         locked;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   johnson_decoder_if #(.WIDTH(W)) bus ();

   johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LOCK), .UNLOCK_ERRS(UNLOCK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   rec_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   int   m_prev, m_state, m_good, m_bad;
   bit   m_dir;
   logic [3:0] exp_idx;
   bit   exp_dir, exp_locked;
   int   exp_err;

   function automatic logic [7:0] code_of(input int k);
      int v;
      if (k <= W) v = (255 << (W - k)) & 255;
      else        v = (1 << (NS - k)) - 1;
      return 8'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_reset();
      m_prev = 0; m_state = 0; m_good = 0; m_bad = 0; m_dir = 0;
      exp_idx = 0; exp_dir = 0; exp_locked = 0; exp_err = 0;
      q.delete();
   endtask

   task automatic model_push(input logic [7:0] c);
      rec_t r;
      int k, d;
      bit up, dn, jmp;
      k = -1;
      for (int i = 0; i < NS; i++) if (code_of(i) == c) k = i;
      r.due = cyc + 2; r.valid = (k >= 0); r.illegal = (k < 0); r.jump = 0; r.idx = 0;
      if (k < 0) begin
         if (m_state == 1) m_state = 0;
         else if (m_state == 2) begin
            m_bad++;
            if (m_bad == UNLOCK) m_state = 0;
         end
      end else begin
         d   = (k - m_prev + NS) % NS;
         up  = (d == 1);
         dn  = (d == NS - 1);
         jmp = (d != 0) && !up && !dn;
         r.jump = jmp; r.idx = 4'(k);
         if (up) m_dir = 1;
         if (dn) m_dir = 0;
         m_prev = k;
         if (m_state == 0) begin
            m_state = 1; m_good = 0;
         end else if (m_state == 1) begin
            if (up || dn) begin
               m_good++;
               if (m_good == LOCK) begin m_state = 2; m_bad = 0; end
            end else if (jmp) m_good = 0;
         end else begin
            if (jmp) begin
               m_bad++;
               if (m_bad == UNLOCK) m_state = 0;
            end else m_bad = 0;
         end
      end
      r.dir = m_dir; r.locked = (m_state == 2);
      q.push_back(r);
   endtask

   task automatic check_cycle();
      rec_t r;
      bit e_v, e_i, e_j;
      e_v = 0; e_i = 0; e_j = 0;
      if (q.size() != 0 && q[0].due == cyc) begin
         r = q.pop_front();
         e_v = r.valid; e_i = r.illegal; e_j = r.jump;
         if (r.valid) exp_idx = r.idx;
         exp_dir = r.dir; exp_locked = r.locked;
         if ((r.illegal || r.jump) && exp_err < 255) exp_err++;
      end
      chk("idx_valid", 32'(bus.idx_valid), 32'(e_v));
      chk("illegal",   32'(bus.illegal),   32'(e_i));
      chk("jump",      32'(bus.jump),      32'(e_j));
      chk("idx_out",   32'(bus.idx_out),   32'(exp_idx));
      chk("dir",       32'(bus.dir),       32'(exp_dir));
      chk("locked",    32'(bus.locked),    32'(exp_locked));
`ifdef JOHNSON_DECODER_ERRCNT_EN
      chk("err_cnt",   32'(bus.err_cnt),   32'(exp_err));
`endif
   endtask

   task automatic step(input bit v, input logic [7:0] c);
      bus.code_valid = v;
      bus.code_in    = c;
      if (v) model_push(c);
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
      bus.code_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.code_valid = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      model_reset();
      check_cycle();
   endtask

   initial begin
      bus.code_valid = 1'b0;
      bus.code_in    = 8'h00;
      model_reset();
      do_reset();

      // ascending ramp to lock
      step(1, 8'h00); step(1, 8'h80); step(1, 8'hC0); step(1, 8'hE0); step(1, 8'hF0);
      step(0, 8'h00); step(0, 8'h00);
      chk("ramp_locked", 32'(bus.locked), 32'd1);
      chk("ramp_idx", 32'(bus.idx_out), 32'd4);
      chk("ramp_dir", 32'(bus.dir), 32'd1);

      // walk up through the top and wrap to 0
      for (int k = 5; k <= 13; k++) step(1, code_of(k));
      step(1, 8'h03); step(1, 8'h01); step(1, 8'h00); step(1, 8'h80);
      step(0, 8'h00); step(0, 8'h00);
      chk("wrap_locked", 32'(bus.locked), 32'd1);
      chk("wrap_idx", 32'(bus.idx_out), 32'd1);

      // descending with wrap 0 -> 15
      step(1, 8'h80); step(1, 8'h00); step(1, 8'h01);
      step(0, 8'h00); step(0, 8'h00);
      chk("down_dir", 32'(bus.dir), 32'd0);
      chk("down_idx", 32'(bus.idx_out), 32'd15);

      // two illegal codes unlock; idx_out holds
      step(1, 8'h5A); step(1, 8'h81);
      step(0, 8'h00); step(0, 8'h00);
      chk("illegal_unlock", 32'(bus.locked), 32'd0);
      chk("illegal_hold_idx", 32'(bus.idx_out), 32'd15);

      // relock with gaps, then jump, recover with up step, jump again stays locked
      step(1, 8'h00); step(0, 8'h00); step(1, 8'h80); step(1, 8'hC0);
      step(0, 8'h00); step(1, 8'hE0); step(1, 8'hF0);
      step(1, 8'h3F); step(1, 8'h1F); step(1, 8'h00);
      step(0, 8'h00); step(0, 8'h00);
      chk("jump_locked", 32'(bus.locked), 32'd1);
      chk("jump_idx", 32'(bus.idx_out), 32'd0);

      // reset with a sample in flight
      step(1, 8'h80);
      do_reset();
      chk("rst_locked", 32'(bus.locked), 32'd0);
      step(1, 8'hC0); step(0, 8'h00); step(0, 8'h00);

      // long run of illegal codes (saturates the optional error counter)
      for (int i = 0; i < 258; i++) step(1, 8'hA5);
      step(0, 8'h00); step(0, 8'h00); step(0, 8'h00);
      chk("drain", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
